// File: rtl/add_arbiter.sv
// Round-robin sequencer sharing one registered W-bit adder between NREQ requesters.
// Optional carry-out output `ovf` is built when ADD_ARB_OVF_EN is defined.
module add_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*W-1:0]  a_in,
  input  logic [NREQ*W-1:0]  b_in,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic [W-1:0]       sum_out,
  output logic               busy,
  output logic [W-1:0]       add_a,
  output logic [W-1:0]       add_b,
  input  logic [W-1:0]       add_sum
`ifdef ADD_ARB_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   ptr_nxt;
  logic            found;
  logic [NREQ-1:0] elig;

`ifdef ADD_ARB_OVF_EN
  // A wrapped W-bit sum is smaller than either operand exactly when a carry left the top bit.
  function automatic logic carry_out(input logic [W-1:0] s, input logic [W-1:0] a);
    return s < a;
  endfunction
`endif

  // Done masks the requester being answered so its still-high req is not reissued.
  always_comb begin
    int idx;
    idx   = 0;
    elig  = req & ~done;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
    ptr_nxt = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= '0;
      grant   <= '0;
      done    <= '0;
      add_a   <= '0;
      add_b   <= '0;
      sum_out <= '0;
`ifdef ADD_ARB_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant <= NREQ'(1) << win;
            add_a <= a_in[int'(win)*W +: W];
            add_b <= b_in[int'(win)*W +: W];
            ptr   <= ptr_nxt;
          end
        end
        RESP: begin
          sum_out <= add_sum;
          done    <= grant;
          grant   <= '0;
`ifdef ADD_ARB_OVF_EN
          ovf     <= carry_out(add_sum, add_a);
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_add_arbiter.sv
// Randomized bench for add_arbiter against a transaction-level reference model.
module tb_add_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] a_in = '0;
  logic [NREQ*W-1:0] b_in = '0;
  logic [NREQ-1:0]   grant, done;
  logic [W-1:0]      sum_out, add_a, add_b, add_sum;
  logic              busy;
`ifdef ADD_ARB_OVF_EN
  logic              ovf;
`endif

  add_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .grant(grant), .done(done), .sum_out(sum_out), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum)
`ifdef ADD_ARB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  // Shared Add instance: one-cycle registered sum, cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) add_sum <= '0;
    else      add_sum <= add_a + add_b;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: cycles elapsed since the current grant (0 = free), plus expected register values.
  int              age;
  int              ptr_m;
  int              txn;
  logic [NREQ-1:0] m_grant, m_done;
  logic [W-1:0]    m_sum, m_a, m_b;
  logic            m_ovf;

  int st[NREQ];
  int mode;
  int dir_k;
  int n_rst;
  logic [W-1:0] dir_a[3];
  logic [W-1:0] dir_b[3];

  task automatic model_reset();
    age = 0; ptr_m = 0;
    m_grant = '0; m_done = '0; m_sum = '0; m_a = '0; m_b = '0; m_ovf = 1'b0;
  endtask

  task automatic check_all();
    chk("grant", 32'(grant), 32'(m_grant));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(age != 0));
    chk("sum_out", 32'(sum_out), 32'(m_sum));
    chk("add_a", 32'(add_a), 32'(m_a));
    chk("add_b", 32'(add_b), 32'(m_b));
`ifdef ADD_ARB_OVF_EN
    chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
  endtask

  // Advance the reference over the next rising edge using the inputs now applied.
  task automatic model_edge();
    logic [NREQ-1:0] elig;
    logic [W:0]      full;
    int              win;
    if (age == 0) begin
      elig = req & ~m_done;
      m_done = '0;
      if (elig != '0) begin
        win = -1;
        for (int k = 0; k < NREQ; k++)
          if (win < 0 && elig[(ptr_m + k) % NREQ]) win = (ptr_m + k) % NREQ;
        m_grant = '0;
        m_grant[win] = 1'b1;
        m_a = a_in[win*W +: W];
        m_b = b_in[win*W +: W];
        ptr_m = (win + 1) % NREQ;
        age = 1;
      end
    end else if (age == 1) begin
      m_done = '0;
      age = 2;
    end else begin
      full = {1'b0, m_a} + {1'b0, m_b};
      m_sum = full[W-1:0];
      m_ovf = full[W];
      m_done = m_grant;
      m_grant = '0;
      age = 0;
      txn++;
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom % 6)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h0001;
      3: return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req[i] = 1'b1;
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
    st[i] = 1;
  endtask

  // Requesters: raise with operands, hold until done, drop one cycle after done.
  task automatic drive();
    bool_all_idle: begin
      int idle_cnt;
      idle_cnt = 0;
      for (int i = 0; i < NREQ; i++) if (st[i] == 0) idle_cnt++;
      if (mode == 0 && dir_k == 3 && idle_cnt == NREQ) mode = 1;
      if (mode == 1 && idle_cnt == NREQ) begin
        for (int i = 0; i < NREQ; i++) raise(i, rnd_op(), rnd_op());
        mode = 2;
        return;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      case (st[i])
        0: begin
          if (mode == 0 && i == 0 && dir_k < 3) begin
            raise(0, dir_a[dir_k], dir_b[dir_k]);
            dir_k++;
          end else if (mode == 2 && ($urandom % 3) == 0) begin
            raise(i, rnd_op(), rnd_op());
          end
        end
        1: begin
          if (m_done[i]) st[i] = 2;
          else if (m_grant[i]) begin
            if (($urandom % 4) == 0) req[i] = 1'b0;
            if (($urandom % 3) == 0) a_in[i*W +: W] = rnd_op();
            if (($urandom % 3) == 0) b_in[i*W +: W] = rnd_op();
          end
        end
        default: begin
          req[i] = 1'b0;
          st[i] = 0;
        end
      endcase
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    req = '0;
    for (int i = 0; i < NREQ; i++) st[i] = 0;
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst = 1'b1;
    n_rst++;
    drive();
    model_edge();
  endtask

  initial begin
    dir_a[0] = 16'h0003; dir_b[0] = 16'h0004;
    dir_a[1] = 16'hFFFF; dir_b[1] = 16'h0001;
    dir_a[2] = 16'h0000; dir_b[2] = 16'h0000;
    mode = 0; dir_k = 0; n_rst = 0; txn = 0;
    for (int i = 0; i < NREQ; i++) st[i] = 0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      check_all();
      if (mode == 2 && age == 2 && n_rst < 4 && ($urandom % 15) == 0) begin
        do_reset();
      end else begin
        drive();
        model_edge();
      end
    end
    chk("progress", 32'(txn > 150), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Round-robin arbiter and sequencer that shares one registered 16-bit ALU adder (`Add`, one-cycle registered latency, `sum` cleared on reset) between NREQ requesters. Each requester raises a level request with its operands. The arbiter grants one requester at a time, drives the adder operands, waits out the adder latency, and returns the sum with a one-cycle `done` pulse. It sits between the ALU's client units (PC increment, address generation, execute stage) and the single shared `Add` instance.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `W`, 16: operand and sum width. Must match `Add` (16).
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `req`  in  NREQ: level request per requester. Held with operands until its `done`.
- `a_in`  in  NREQ*W: operand A, requester i at bits [i*W +: W].
- `b_in`  in  NREQ*W: operand B, same packing.
- `grant`  out  NREQ: one-hot, registered. Marks the requester currently owning the adder.
- `done`  out  NREQ: one-hot, single-cycle pulse. Result for that requester is on `sum_out`.
- `sum_out`  out  W: registered result. Holds its value until the next `done`.
- `busy`  out  1: high whenever the state is not IDLE.
- `add_a`, `add_b`  out  W: registered operands to the `Add` instance.
- `add_sum`  in  W: `sum` output of the `Add` instance.
- `ovf`  out  1: carry out of the last add. Present only with `ADD_ARB_OVF_EN`.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- **IDLE:**
  - Eligible set = `req & ~done`. Masking by `done` prevents a double issue during the `done` cycle.
  - If the eligible set is non-empty, pick the winner by round-robin. Search starts at index `ptr` and wraps through NREQ-1 back to 0.
  - Register `grant` = one-hot of the winner.
  - Register `add_a` = `a_in[win]` and `add_b` = `b_in[win]`.
  - Set `ptr` = (win+1) mod NREQ. Go to EXEC.
  - If the eligible set is empty, stay in IDLE. `grant`, `add_a`, `add_b` and `ptr` hold.
- **EXEC:** the adder registers `add_a + add_b` at the end of this cycle. Go to RESP unconditionally.
- **RESP:**
  - `add_sum` is valid.
  - Register `sum_out` = `add_sum` and `done` = `grant`.
  - Clear `grant` to 0. Go to IDLE.
- **Arithmetic:** modulo 2^W. Wrap-around is not an error (FFFF+0001 = 0000).
- **Requester changes:**
  - A requester that drops `req` after grant still completes; it receives the `done` pulse.
  - Operand changes after grant are ignored, because the operands were latched in IDLE.
- **Simultaneous requests:** exactly one grant per transaction. Losers stay pending and are served in round-robin order with no starvation. Worst-case wait is (NREQ-1) transactions.
- **Reset (async, any state, including mid-transaction):**
  - state = IDLE, `ptr` = 0.
  - `grant`, `done`, `add_a`, `add_b`, `sum_out`, `busy` and `ovf` all 0.
  - The in-flight transaction is lost and no `done` is issued. Requesters must re-request after reset is released.

## Timing
- Edge numbering:
  - Cycle 0 is the cycle in which `req` is sampled in IDLE.
  - Edge E1 latches `grant`, `add_a` and `add_b`.
  - Edge E2 latches the adder `sum`.
  - Edge E3 latches `sum_out`, `done` and `ovf`.
- `done` and `sum_out` are visible in cycle 3, so latency is 3 cycles from request sample to `done`.
- `busy` is high in cycles 1-2 (EXEC, RESP).
- The arbiter re-enters IDLE in cycle 3, which can also issue a new grant. Back-to-back throughput is one result per 3 cycles.
- A requester must deassert `req` in the cycle after its `done`, or a new transaction is issued for it.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `ADD_ARB_OVF_EN` defined:
  - Output `ovf` exists.
  - In RESP, `ovf` is registered as (`add_sum` < `add_a`) unsigned, i.e. the carry out of the W-bit add.
  - `ovf` updates with `done` and holds until the next `done`.
- `ADD_ARB_OVF_EN` undefined:
  - Port `ovf` and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then `req`=0001 with A=0003, B=0004 → `grant`=0001 at cycle 1; `done`=0001 and `sum_out`=0007 at cycle 3; `busy`=1 in cycles 1-2 only.
- `req`0 with A=FFFF, B=0001 → `sum_out`=0000. With `ADD_ARB_OVF_EN`, `ovf`=1. Then A=0000, B=0000 → `sum_out`=0000, `ovf`=0.
- `req`=1111 held, each requester dropping `req` the cycle after its `done` → grants in order 0001, 0010, 0100, 1000; `done` pulses 3 cycles apart; sums correct per requester.
- Requester 2 completes, then `req`=0101 simultaneously → requester 0 is granted first, because `ptr`=3 wraps to 0; requester 2 follows.
- Change `a_in[0]` from 0005 to 00FF in cycle 1 → `sum_out` uses 0005; `req` dropped in cycle 1 still yields a `done` pulse.
- Assert `rst`=0 in cycle 2 (RESP) → all outputs 0 immediately; no `done`; after release, `req`=0010 is granted first.
